// File: rtl/debug_abstract_cmd_sequencer.sv
// debug_abstract_cmd_sequencer
//   Turns debug-module "access register" abstract commands into short
//   sequences of RISC-V CSR instructions injected into the core's
//   debug-mode instruction port. DSCRATCH is the data mailbox: it is
//   preloaded for writes and sampled for reads.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/ready/write/regno/wdata abstract command from the debug module
//   scratch_we/wdata, scratch_rdata  DSCRATCH preload and current value
//   inst_valid/ready, inst           instruction injection handshake
//   exec_done, exec_exception        retirement status of injected instruction
//   rsp_valid/ready, rsp_data/err    command response (err 0/2/3)
module debug_abstract_cmd_sequencer #(
    parameter logic [11:0] DSCRATCH_ADDR = 12'h7B2,
    parameter logic [4:0]  TEMP_REG      = 5'd8,
    parameter logic [15:0] GPR_BASE      = 16'h1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_regno,
    input  logic [31:0] cmd_wdata,
    output logic        scratch_we,
    output logic [31:0] scratch_wdata,
    input  logic [31:0] scratch_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    input  logic        exec_done,
    input  logic        exec_exception,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_err
);

    typedef enum logic [2:0] {IDLE, PRELOAD, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] FN_CSRRW  = 3'b001;
    localparam logic [2:0] FN_CSRRS  = 3'b010;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_NOSUP = 3'd2;
    localparam logic [2:0] ERR_EXC   = 3'd3;

    state_t      state_q, state_d;
    logic [1:0]  step_q;
    logic        wr_q, csr_q, exc_q;
    logic [11:0] csr_addr_q;
    logic [4:0]  gpr_q;
    logic [31:0] wdata_q;
    logic [31:0] rsp_data_q;
    logic [2:0]  rsp_err_q;

    logic [15:0] gpr_off;
    logic        cmd_is_csr, cmd_is_gpr;
    logic        mid_step, last_step;

    assign gpr_off    = cmd_regno - GPR_BASE;
    assign cmd_is_csr = cmd_regno < 16'h1000;
    assign cmd_is_gpr = (cmd_regno >= GPR_BASE) && (gpr_off < 16'd32);
    assign mid_step   = csr_q && (step_q == 2'd1);
    assign last_step  = csr_q ? (step_q == 2'd2) : (step_q == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cmd_valid) begin
                if (!(cmd_is_csr || cmd_is_gpr)) state_d = RESP;
                else if (cmd_write)              state_d = PRELOAD;
                else                             state_d = ISSUE;
            end
            PRELOAD: state_d = ISSUE;
            ISSUE:   if (inst_ready) state_d = WAIT;
            // A trap on the middle CSR step still issues the final step so
            // the borrowed temp register gets restored.
            WAIT: if (exec_done) begin
                if (exec_exception) state_d = mid_step ? ISSUE : RESP;
                else                state_d = last_step ? RESP : ISSUE;
            end
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q     <= '0;
            wr_q       <= 1'b0;
            csr_q      <= 1'b0;
            exc_q      <= 1'b0;
            csr_addr_q <= '0;
            gpr_q      <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= '0;
        end else begin
            if (state_q == IDLE && cmd_valid) begin
                wr_q       <= cmd_write;
                csr_q      <= cmd_is_csr;
                csr_addr_q <= cmd_regno[11:0];
                gpr_q      <= gpr_off[4:0];
                wdata_q    <= cmd_wdata;
                step_q     <= '0;
                exc_q      <= 1'b0;
                rsp_data_q <= '0;
                rsp_err_q  <= (cmd_is_csr || cmd_is_gpr) ? ERR_NONE : ERR_NOSUP;
            end
            if (state_q == WAIT && exec_done) begin
                if (exec_exception) exc_q <= 1'b1;
                if (state_d == ISSUE) step_q <= step_q + 2'd1;
                if (state_d == RESP) begin
                    rsp_err_q  <= (exc_q || exec_exception) ? ERR_EXC : ERR_NONE;
                    rsp_data_q <= (!wr_q && !exc_q && !exec_exception) ? scratch_rdata : '0;
                end
            end
            if (state_q == RESP && rsp_ready) begin
                rsp_data_q <= '0;
                rsp_err_q  <= '0;
            end
        end
    end

    logic [11:0] f_csr;
    logic [4:0]  f_rs1, f_rd;
    logic [2:0]  f_fn3;

    always_comb begin
        f_csr = DSCRATCH_ADDR;
        f_rs1 = TEMP_REG;
        f_fn3 = FN_CSRRW;
        f_rd  = TEMP_REG;
        if (!csr_q) begin
            if (wr_q) begin
                f_rs1 = '0;
                f_fn3 = FN_CSRRS;
                f_rd  = gpr_q;
            end else begin
                f_rs1 = gpr_q;
                f_rd  = '0;
            end
        end else if (step_q == 2'd1) begin
            f_csr = csr_addr_q;
            if (wr_q) begin
                f_rd  = '0;
            end else begin
                f_rs1 = '0;
                f_fn3 = FN_CSRRS;
            end
        end
    end

    always_comb begin
        cmd_ready     = (state_q == IDLE);
        scratch_we    = (state_q == PRELOAD);
        scratch_wdata = (state_q == PRELOAD) ? wdata_q : '0;
        inst_valid    = (state_q == ISSUE);
        inst          = (state_q == ISSUE) ? {f_csr, f_rs1, f_fn3, f_rd, OP_SYSTEM} : '0;
        rsp_valid     = (state_q == RESP);
        rsp_data      = rsp_data_q;
        rsp_err       = rsp_err_q;
    end

endmodule

// File: tb/tb_debug_abstract_cmd_sequencer.sv
module tb_debug_abstract_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_regno;
    logic [31:0] cmd_wdata;
    logic        scratch_we;
    logic [31:0] scratch_wdata, scratch_rdata;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic        exec_done, exec_exception;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_err;

    always #5 clk = ~clk;

    debug_abstract_cmd_sequencer #(
        .DSCRATCH_ADDR(12'h7B2),
        .TEMP_REG(5'd8),
        .GPR_BASE(16'h1000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_regno(cmd_regno), .cmd_wdata(cmd_wdata),
        .scratch_we(scratch_we), .scratch_wdata(scratch_wdata), .scratch_rdata(scratch_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .exec_done(exec_done), .exec_exception(exec_exception),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    int checks = 0;
    int errors = 0;

    // observations of one command
    logic [31:0] got_insts[$];
    int          got_we;
    logic [31:0] got_we_data;
    bit          got_rsp;
    logic [31:0] got_rsp_data;
    logic [2:0]  got_rsp_err;
    int          unstable, busy_ready, lat;
    bit          timed_out, post_ready, post_rspv;
    bit          rand_scratch;
    logic [31:0] last_scratch;

    // reference expectations
    logic [31:0] exp_insts[$];
    int          exp_we;
    logic [2:0]  exp_err;
    logic [31:0] exp_data;

    function automatic logic [31:0] enc(input longint csr, input longint rs1,
                                        input longint fn3, input longint rd);
        longint v;
        v = csr * 1048576 + rs1 * 32768 + fn3 * 4096 + rd * 128 + 115;
        return 32'(v);
    endfunction

    // Expected instruction list, error and data computed from the command rules.
    function automatic void build_model(input bit wr, input int regno, input int exc_step);
        logic [31:0] seq[$];
        int keep;
        exp_insts.delete();
        exp_we   = 0;
        exp_err  = 3'd0;
        exp_data = '0;
        if (regno >= 'h1020) begin
            exp_err = 3'd2;
            return;
        end
        if (wr) exp_we = 1;
        if (regno < 'h1000) begin
            seq.push_back(enc('h7B2, 8, 1, 8));
            seq.push_back(wr ? enc(regno, 8, 1, 0) : enc(regno, 0, 2, 8));
            seq.push_back(enc('h7B2, 8, 1, 8));
        end else begin
            seq.push_back(wr ? enc('h7B2, 0, 2, regno - 'h1000) : enc('h7B2, regno - 'h1000, 1, 0));
        end
        keep = seq.size();
        if (exc_step >= 0 && exc_step < seq.size()) begin
            exp_err = 3'd3;
            keep = (seq.size() == 3 && exc_step == 1) ? 3 : exc_step + 1;
        end
        for (int i = 0; i < keep; i++) exp_insts.push_back(seq[i]);
        if (!wr && exp_err == 3'd0) exp_data = last_scratch;
    endfunction

    // Drives one command from a negedge and plays the core: inst_ready after
    // ready_lag cycles, exec_done after done_lag, trap on step exc_step.
    task automatic run_cmd(input bit wr, input logic [15:0] regno, input logic [31:0] wdata,
                           input int exc_step, input int ready_lag, input int done_lag);
        int vcnt = 0;
        int wcnt = 0;
        int rcnt = 0;
        bit waiting = 0;
        bit finished = 0;
        logic [31:0] held = '0;
        got_insts.delete();
        got_we = 0; got_we_data = '0; got_rsp = 0; got_rsp_data = '0; got_rsp_err = '0;
        unstable = 0; busy_ready = 0; lat = -1; timed_out = 1; post_ready = 0; post_rspv = 1;
        last_scratch = scratch_rdata;
        cmd_valid = 1'b1; cmd_write = wr; cmd_regno = regno; cmd_wdata = wdata;
        @(posedge clk);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0; inst_ready = 1'b0; exec_done = 1'b0;
            exec_exception = 1'b0; rsp_ready = 1'b0;
            if (finished) begin
                post_ready = cmd_ready;
                post_rspv  = rsp_valid;
                timed_out  = 0;
                break;
            end
            if (cmd_ready) busy_ready++;
            if (scratch_we) begin
                got_we++;
                got_we_data = scratch_wdata;
            end
            if (rsp_valid) begin
                if (!got_rsp) begin
                    got_rsp = 1; lat = k + 1;
                    got_rsp_data = rsp_data; got_rsp_err = rsp_err;
                end else if (rsp_data !== got_rsp_data || rsp_err !== got_rsp_err) begin
                    unstable++;
                end
                if (inst_valid) unstable++;
                if (rcnt >= ready_lag) begin
                    rsp_ready = 1'b1;
                    finished = 1;
                end else rcnt++;
            end else if (inst_valid) begin
                if (vcnt == 0) held = inst;
                else if (inst !== held) unstable++;
                if (vcnt >= ready_lag) begin
                    inst_ready = 1'b1;
                    got_insts.push_back(inst);
                    waiting = 1; wcnt = 0; vcnt = 0;
                end else vcnt++;
            end else if (waiting) begin
                if (wcnt >= done_lag) begin
                    exec_done = 1'b1;
                    exec_exception = (got_insts.size() - 1 == exc_step);
                    if (rand_scratch) scratch_rdata = $urandom;
                    last_scratch = scratch_rdata;
                    waiting = 0; wcnt = 0;
                end else wcnt++;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({cmd_ready, scratch_we, inst_valid, rsp_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 1000", {cmd_ready, scratch_we, inst_valid, rsp_valid});
        end
        checks++;
        if ({inst, rsp_data, scratch_wdata, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_data inst %h rsp_data %h wdata %h err %0d want all 0",
                     inst, rsp_data, scratch_wdata, rsp_err);
        end
    endtask

    task automatic test_gpr_read();
        rand_scratch = 0;
        scratch_rdata = 32'hDEADBEEF;
        run_cmd(1'b0, 16'h1005, 32'h0, -1, 0, 0);
        checks++;
        if (got_insts.size() !== 1 || got_insts[0] !== 32'h7B229073) begin
            errors++;
            $display("FAIL gpr_read_inst got n=%0d first %h want 1 x 7b229073",
                     got_insts.size(), got_insts.size() > 0 ? got_insts[0] : 32'h0);
        end
        checks++;
        if (got_rsp_data !== 32'hDEADBEEF || got_rsp_err !== 3'd0) begin
            errors++;
            $display("FAIL gpr_read_rsp got %h/%0d want deadbeef/0", got_rsp_data, got_rsp_err);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL gpr_read_latency got %0d want 3", lat);
        end
        checks++;
        if (got_we !== 0 || timed_out || busy_ready !== 0) begin
            errors++;
            $display("FAIL gpr_read_side we %0d timeout %0d busy_ready %0d want 0 0 0",
                     got_we, timed_out, busy_ready);
        end
    endtask

    task automatic test_gpr_write();
        run_cmd(1'b1, 16'h1005, 32'h12345678, -1, 0, 1);
        checks++;
        if (got_we !== 1 || got_we_data !== 32'h12345678) begin
            errors++;
            $display("FAIL gpr_write_preload got %0d pulses data %h want 1 x 12345678", got_we, got_we_data);
        end
        checks++;
        if (got_insts.size() !== 1 || got_insts[0] !== 32'h7B2022F3) begin
            errors++;
            $display("FAIL gpr_write_inst got n=%0d first %h want 1 x 7b2022f3",
                     got_insts.size(), got_insts.size() > 0 ? got_insts[0] : 32'h0);
        end
        checks++;
        if (got_rsp_data !== 32'h0 || got_rsp_err !== 3'd0) begin
            errors++;
            $display("FAIL gpr_write_rsp got %h/%0d want 0/0", got_rsp_data, got_rsp_err);
        end
    endtask

    task automatic test_csr_read();
        logic [31:0] want[3];
        want[0] = 32'h7B241473; want[1] = 32'h30002473; want[2] = 32'h7B241473;
        rand_scratch = 1;
        run_cmd(1'b0, 16'h0300, 32'h0, -1, 0, 2);
        checks++;
        if (got_insts.size() !== 3) begin
            errors++;
            $display("FAIL csr_read_count got %0d want 3", got_insts.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_insts[i] !== want[i]) begin
                    errors++;
                    $display("FAIL csr_read_inst%0d got %h want %h", i, got_insts[i], want[i]);
                end
            end
        end
        checks++;
        if (got_rsp_data !== last_scratch || got_rsp_err !== 3'd0) begin
            errors++;
            $display("FAIL csr_read_rsp got %h/%0d want %h/0", got_rsp_data, got_rsp_err, last_scratch);
        end
    endtask

    task automatic test_csr_write_exception();
        run_cmd(1'b1, 16'h0300, 32'hCAFEF00D, 1, 0, 0);
        checks++;
        if (got_insts.size() !== 3 || got_insts[1] !== 32'h30041073 || got_insts[2] !== 32'h7B241473) begin
            errors++;
            $display("FAIL csr_write_exc_seq got n=%0d want 3 ending 30041073 7b241473", got_insts.size());
        end
        checks++;
        if (got_rsp_err !== 3'd3 || got_rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL csr_write_exc_rsp got %h/%0d want 0/3", got_rsp_data, got_rsp_err);
        end
    endtask

    task automatic test_unsupported();
        run_cmd(1'b1, 16'h2000, 32'h55AA55AA, -1, 0, 0);
        checks++;
        if (got_insts.size() !== 0 || got_we !== 0) begin
            errors++;
            $display("FAIL unsup_side got insts %0d we %0d want 0 0", got_insts.size(), got_we);
        end
        checks++;
        if (got_rsp_err !== 3'd2 || got_rsp_data !== 32'h0 || timed_out) begin
            errors++;
            $display("FAIL unsup_rsp got %h/%0d timeout %0d want 0/2", got_rsp_data, got_rsp_err, timed_out);
        end
    endtask

    task automatic test_stall();
        rand_scratch = 1;
        run_cmd(1'b0, 16'h0341, 32'h0, -1, 5, 3);
        checks++;
        if (unstable !== 0 || got_insts.size() !== 3) begin
            errors++;
            $display("FAIL stall_hold got unstable %0d issues %0d want 0 3", unstable, got_insts.size());
        end
        checks++;
        if (got_rsp_data !== last_scratch) begin
            errors++;
            $display("FAIL stall_rsp got %h want %h", got_rsp_data, last_scratch);
        end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_regno = 16'h1003; cmd_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        inst_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inst_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || inst_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait got ready %b valid %b rsp %b want 000", cmd_ready, inst_valid, rsp_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, scratch_we, inst_valid, rsp_valid} !== 4'b1000 || {inst, rsp_data, rsp_err} !== '0) begin
            errors++;
            $display("FAIL mid_reset got ctrl %b inst %h data %h err %0d want 1000 and zeros",
                     {cmd_ready, scratch_we, inst_valid, rsp_valid}, inst, rsp_data, rsp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rand_scratch = 0;
        scratch_rdata = 32'h0BADF00D;
        run_cmd(1'b0, 16'h1003, 32'h0, -1, 0, 0);
        checks++;
        if (got_insts.size() !== 1 || got_rsp_data !== 32'h0BADF00D || got_rsp_err !== 3'd0) begin
            errors++;
            $display("FAIL after_reset got n=%0d data %h err %0d want 1 0badf00d 0",
                     got_insts.size(), got_rsp_data, got_rsp_err);
        end
    endtask

    task automatic test_random();
        rand_scratch = 1;
        for (int it = 0; it < 40; it++) begin
            bit          wr;
            int          sel, regno, exc;
            logic [31:0] wd;
            wr  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            if (sel <= 1)      regno = 'h1000 + $urandom_range(0, 31);
            else if (sel == 2) regno = $urandom_range(0, 'hFFF);
            else               regno = $urandom_range('h1020, 'hFFFF);
            exc = $urandom_range(0, 6);
            if (exc > 2) exc = -1;
            wd = $urandom;
            run_cmd(wr, 16'(regno), wd, exc, $urandom_range(0, 3), $urandom_range(0, 3));
            build_model(wr, regno, exc);
            checks++;
            if (timed_out || got_insts.size() != exp_insts.size()) begin
                errors++;
                $display("FAIL rand%0d_count regno %h got %0d insts timeout %0d want %0d",
                         it, regno, got_insts.size(), timed_out, exp_insts.size());
            end else begin
                for (int i = 0; i < exp_insts.size(); i++) begin
                    checks++;
                    if (got_insts[i] !== exp_insts[i]) begin
                        errors++;
                        $display("FAIL rand%0d_inst%0d got %h want %h", it, i, got_insts[i], exp_insts[i]);
                    end
                end
            end
            checks++;
            if (got_we !== exp_we || (exp_we == 1 && got_we_data !== wd)) begin
                errors++;
                $display("FAIL rand%0d_preload got %0d/%h want %0d/%h", it, got_we, got_we_data, exp_we, wd);
            end
            checks++;
            if (got_rsp_err !== exp_err || got_rsp_data !== exp_data) begin
                errors++;
                $display("FAIL rand%0d_rsp got %h/%0d want %h/%0d", it, got_rsp_data, got_rsp_err, exp_data, exp_err);
            end
            checks++;
            if (unstable !== 0 || busy_ready !== 0 || post_ready !== 1'b1 || post_rspv !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_handshake unstable %0d busy %0d post_ready %b post_rsp %b want 0 0 1 0",
                         it, unstable, busy_ready, post_ready, post_rspv);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_regno = '0; cmd_wdata = '0;
        scratch_rdata = '0; inst_ready = 1'b0; exec_done = 1'b0;
        exec_exception = 1'b0; rsp_ready = 1'b0; rand_scratch = 0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_gpr_read();
        test_gpr_write();
        test_csr_read();
        test_csr_write_exception();
        test_unsupported();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
